// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode encodings and shared types for the pipelined ALU.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_INC = 3'd2;
  localparam logic [OP_W-1:0] OP_DEC = 3'd3;
  localparam logic [OP_W-1:0] OP_AND = 3'd4;
  localparam logic [OP_W-1:0] OP_OR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR = 3'd6;
  localparam logic [OP_W-1:0] OP_NOT = 3'd7;

  typedef struct packed {
    logic co;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_if
// Brief    : Command/result handshake bundle for alu_pipe.
// Revision : 1.0
// ============================================================================
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  s;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             acc_sel;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             co;
  logic             z;
  logic             n;
  logic             v;
  logic [WIDTH-1:0] acc;

  modport slave (
    input  in_valid, s, a, b, cin, acc_sel, acc_clr, out_ready,
    output in_ready, out_valid, y, co, z, n, v, acc
  );

  modport master (
    output in_valid, s, a, b, cin, acc_sel, acc_clr, out_ready,
    input  in_ready, out_valid, y, co, z, n, v, acc
  );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Combinational 8-op ALU producing result, carry-out and overflow.
// Revision : 1.0
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OP_W-1:0]  s_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] y_o,
  output logic             co_o,
  output logic             v_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] addend;
  logic             carry;
  logic             arith;
  logic [WIDTH:0]   sum;

  always_comb begin
    addend = b_i;
    carry  = cin_i;
    arith  = 1'b1;
    y_o    = '0;
    co_o   = 1'b0;
    v_o    = 1'b0;

    // Every arithmetic op is a + addend + carry; overflow uses the effective addend
    case (s_i)
      OP_ADD:  begin addend = b_i;  carry = cin_i; end
      OP_SUB:  begin addend = ~b_i; carry = cin_i; end
      OP_INC:  begin addend = '0;   carry = 1'b1;  end
      OP_DEC:  begin addend = '1;   carry = 1'b0;  end
      default: arith = 1'b0;
    endcase

    sum = {1'b0, a_i} + {1'b0, addend} + {{WIDTH{1'b0}}, carry};

    if (arith) begin
      y_o  = sum[MSB:0];
      co_o = sum[WIDTH];
      v_o  = (a_i[MSB] == addend[MSB]) && (sum[MSB] != a_i[MSB]);
    end else begin
      case (s_i)
        OP_AND:  y_o = a_i & b_i;
        OP_OR:   y_o = a_i | b_i;
        OP_XOR:  y_o = a_i ^ b_i;
        default: y_o = ~a_i;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Two-stage pipelined ALU with valid/ready handshake and accumulator.
// Revision : 1.0
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave bus
);

  logic             s1_valid_q;
  logic [OP_W-1:0]  s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_cin_q;
  logic             s1_acc_sel_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  alu_flags_t       flags_q;
  logic [WIDTH-1:0] acc_q;

  logic             adv2;
  logic             in_ready;
  logic             accept;
  logic             s1_fire;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] y_d;
  logic             co_d;
  logic             v_d;
  alu_flags_t       flags_d;

  assign adv2     = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || adv2;
  assign accept   = bus.in_valid && in_ready;
  assign s1_fire  = s1_valid_q && adv2;
  assign op_b     = s1_acc_sel_q ? acc_q : s1_b_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .s_i   (s1_op_q),
    .a_i   (s1_a_q),
    .b_i   (op_b),
    .cin_i (s1_cin_q),
    .y_o   (y_d),
    .co_o  (co_d),
    .v_o   (v_d)
  );

  assign flags_d = '{co: co_d, z: (y_d == '0), n: y_d[WIDTH-1], v: v_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_ADD;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_cin_q     <= 1'b0;
      s1_acc_sel_q <= 1'b0;
    end else if (accept) begin
      s1_valid_q   <= 1'b1;
      s1_op_q      <= bus.s;
      s1_a_q       <= bus.a;
      s1_b_q       <= bus.b;
      s1_cin_q     <= bus.cin;
      s1_acc_sel_q <= bus.acc_sel;
    end else if (s1_fire) begin
      s1_valid_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        y_q     <= y_d;
        flags_q <= flags_d;
      end
    end
  end

  // Writeback lands on the same edge S2 loads, so the next op in S1 sees it
  always_ff @(posedge clk) begin
    if (rst || bus.acc_clr) begin
      acc_q <= ACC_INIT;
    end else if (s1_fire && s1_acc_sel_q) begin
      acc_q <= y_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.co        = flags_q.co;
  assign bus.z         = flags_q.z;
  assign bus.n         = flags_q.n;
  assign bus.v         = flags_q.v;
  assign bus.acc       = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Directed-vector self-checking bench for alu_pipe (WIDTH=4).
// Revision : 1.0
// ============================================================================
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_pipe_if #(.WIDTH(4)) bus ();

  alu_pipe #(.WIDTH(4), .ACC_INIT(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       acc_sel;
    logic [3:0] exp_y;
    logic [3:0] exp_f;   // {co,z,n,v}
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out waiting for handshake", name);
  endtask

  task automatic do_op(input string name, input vec_t v);
    bit got;
    @(negedge clk);
    bus.s        = v.s;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.cin      = v.cin;
    bus.acc_sel  = v.acc_sel;
    bus.in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) timeout_fail({name, "_accept"});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      timeout_fail({name, "_result"});
    end else begin
      chk({name, "_y"}, 32'(bus.y), 32'(v.exp_y));
      chk({name, "_flags"}, 32'({bus.co, bus.z, bus.n, bus.v}), 32'(v.exp_f));
    end
  endtask

  logic [3:0] exp4[4];
  int         tx;
  int         rx;
  bit         take;

  initial begin
    checks   = 0;
    failures = 0;

    //        s       a     b     cin  sel  y     {co,z,n,v}
    vecs[0]  = '{OP_ADD, 4'h3, 4'hA, 1'b1, 1'b0, 4'hE, 4'b0010};
    vecs[1]  = '{OP_SUB, 4'h3, 4'hA, 1'b1, 1'b0, 4'h9, 4'b0011};
    vecs[2]  = '{OP_INC, 4'h3, 4'hA, 1'b1, 1'b0, 4'h4, 4'b0000};
    vecs[3]  = '{OP_DEC, 4'h3, 4'hA, 1'b1, 1'b0, 4'h2, 4'b1000};
    vecs[4]  = '{OP_AND, 4'h3, 4'hA, 1'b1, 1'b0, 4'h2, 4'b0000};
    vecs[5]  = '{OP_OR,  4'h3, 4'hA, 1'b1, 1'b0, 4'hB, 4'b0010};
    vecs[6]  = '{OP_XOR, 4'h3, 4'hA, 1'b1, 1'b0, 4'h9, 4'b0010};
    vecs[7]  = '{OP_NOT, 4'h3, 4'hA, 1'b1, 1'b0, 4'hC, 4'b0010};
    vecs[8]  = '{OP_INC, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 4'b1100};
    vecs[9]  = '{OP_ADD, 4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 4'b0011};
    vecs[10] = '{OP_SUB, 4'h5, 4'h5, 1'b1, 1'b0, 4'h0, 4'b1100};
    vecs[11] = '{OP_ADD, 4'h5, 4'hF, 1'b0, 1'b1, 4'h5, 4'b0000};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.s         = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.acc_sel   = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_flags", 32'({bus.co, bus.z, bus.n, bus.v}), 32'd0);
    chk("rst_acc", 32'(bus.acc), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Op sweep, wrap cases, accumulator as operand B
    for (int i = 0; i < 12; i++) do_op($sformatf("vec%0d", i), vecs[i]);
    chk("acc_after_vec11", 32'(bus.acc), 32'h5);

    // Accumulate: clear, then three back-to-back acc ops
    @(negedge clk);
    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr  = 1'b0;
    chk("acc_cleared", 32'(bus.acc), 32'h0);
    bus.s        = OP_ADD;
    bus.a        = 4'h1;
    bus.b        = 4'hF;
    bus.cin      = 1'b0;
    bus.acc_sel  = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("accum_lat_ov0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("accum_ov1", 32'(bus.out_valid), 32'd1);
    chk("accum_y1", 32'(bus.y), 32'h1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("accum_y2", 32'(bus.y), 32'h2);
    @(negedge clk);
    chk("accum_y3", 32'(bus.y), 32'h3);
    chk("accum_ov3", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("accum_ov_end", 32'(bus.out_valid), 32'd0);
    chk("accum_acc", 32'(bus.acc), 32'h3);

    // Stall: 4 cycles of out_ready=0 while offering 4 ops, then release
    exp4[0] = 4'h2; exp4[1] = 4'h4; exp4[2] = 4'h6; exp4[3] = 4'h8;
    tx = 0;
    rx = 0;
    bus.s       = OP_ADD;
    bus.cin     = 1'b0;
    bus.acc_sel = 1'b0;
    for (int cyc = 0; cyc < 24 && rx < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 4) begin
        chk("stall_accepted", 32'(tx), 32'd2);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_y_held", 32'(bus.y), 32'h2);
      end
      bus.out_ready = (cyc >= 4);
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("stall_out%0d", rx), 32'(bus.y), 32'(exp4[rx]));
        rx++;
      end
      if (tx < 4) begin
        bus.a        = 4'(tx + 1);
        bus.b        = 4'(tx + 1);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1 take = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (take) tx++;
    end
    bus.in_valid = 1'b0;
    chk("stall_rx_count", 32'(rx), 32'd4);
    @(negedge clk);
    chk("stall_no_dup", 32'(bus.out_valid), 32'd0);

    // acc_clr coincident with acc_sel writeback: clear wins
    @(negedge clk);
    bus.s        = OP_ADD;
    bus.a        = 4'h5;
    bus.b        = 4'h0;
    bus.cin      = 1'b0;
    bus.acc_sel  = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b1;
    @(negedge clk);
    bus.acc_clr  = 1'b0;
    chk("clrwb_y", 32'(bus.y), 32'h8);
    chk("clrwb_acc", 32'(bus.acc), 32'h0);
    do_op("clrwb_next", '{OP_ADD, 4'h2, 4'hF, 1'b0, 1'b1, 4'h2, 4'b0000});
    chk("clrwb_acc_next", 32'(bus.acc), 32'h2);

    // Reset with S1 and S2 full and stalled
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.s         = OP_ADD;
    bus.a         = 4'h1;
    bus.cin       = 1'b0;
    bus.acc_sel   = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.s        = OP_AND;
    bus.a        = 4'hF;
    bus.b        = 4'hF;
    bus.acc_sel  = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_acc", 32'(bus.acc), 32'h3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_y", 32'(bus.y), 32'd0);
    chk("midrst_flags", 32'({bus.co, bus.z, bus.n, bus.v}), 32'd0);
    chk("midrst_acc", 32'(bus.acc), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_no_ghost", 32'(bus.out_valid), 32'd0);
    do_op("postrst", '{OP_ADD, 4'h1, 4'h1, 1'b0, 1'b0, 4'h2, 4'b0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
